// File: rtl/debug_state_dumper.sv
// Read-back engine beside the core: freezes the pipeline, then streams every register-file
// word followed by a window of data memory over a valid/ready port, tagged {is_mem, index}.
`timescale 1ns/1ps
module debug_state_dumper #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int MEM_WORDS  = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  halt_req,
    input  logic                  pipe_empty,
    output logic [4:0]            rf_raddr,
    input  logic [DATA_WIDTH-1:0] rf_rdata,
    output logic [31:0]           dmem_raddr,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [8:0]            out_tag,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            dbg_state
);

    // Output handshake: a beat transfers on a rising edge where out_valid && out_ready.
    // While out_valid is high and out_ready is low, out_data/out_tag hold their value;
    // a beat may be accepted and the next one loaded on the same edge.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_REGS  = 3'd2,
        S_MEM   = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [8:0] LAST_REG = 9'(NUM_REGS - 1);
    localparam logic [8:0] LAST_MEM = (MEM_WORDS > 0) ? 9'(MEM_WORDS - 1) : 9'd0;

    state_t     state;
    state_t     next_state;
    logic [8:0] idx;
    logic       pipe_empty_q;
    logic       load;
    logic       last_reg;
    logic       last_mem;

    assign last_reg = (idx == LAST_REG);
    assign last_mem = (idx == LAST_MEM);
    assign load     = ((state == S_REGS) || (state == S_MEM)) && (!out_valid || out_ready);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_HALT;
            S_HALT:  if (pipe_empty_q) next_state = S_REGS;
            S_REGS:  if (load && last_reg) next_state = (MEM_WORDS == 0) ? S_DRAIN : S_MEM;
            S_MEM:   if (load && last_mem) next_state = S_DRAIN;
            S_DRAIN: if (out_valid && out_ready) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        halt_req   = 1'b0;
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        rf_raddr   = '0;
        dmem_raddr = '0;
        dbg_state  = state;
        case (state)
            S_HALT, S_DRAIN: halt_req = 1'b1;
            S_REGS: begin
                halt_req = 1'b1;
                rf_raddr = idx[4:0];
            end
            S_MEM: begin
                halt_req   = 1'b1;
                dmem_raddr = {21'd0, idx, 2'b00};
            end
            default: halt_req = 1'b0;
        endcase
    end

    // pipe_empty is only trusted once halt_req has been visible to the core for a cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx          <= '0;
            pipe_empty_q <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_tag      <= '0;
        end else begin
            pipe_empty_q <= (state == S_HALT) && pipe_empty;
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= (state == S_REGS) ? rf_rdata : dmem_rdata;
                out_tag   <= {state == S_MEM, idx[7:0]};
                idx       <= ((state == S_REGS) && last_reg) ? 9'd0 : idx + 9'd1;
            end else begin
                if (out_ready) begin
                    out_valid <= 1'b0;
                end
                if ((state == S_IDLE) || (state == S_HALT)) begin
                    idx <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_debug_state_dumper.sv
// Bench for debug_state_dumper: a full-size instance and a MEM_WORDS=0 instance run side by
// side against a register/memory model, with expected beats queued per dump.
`timescale 1ns/1ps
module tb_debug_state_dumper;

    localparam int DW   = 32;
    localparam int NREG = 32;
    localparam int NMEM = 10;

    typedef struct {
        int pe_delay;
        int ready_pct;
        bit noise;
        int exp_cycles;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic start0 = 1'b0;
    logic pipe_empty = 1'b0;
    logic out_ready = 1'b0;

    logic          halt_req, out_valid, busy, done;
    logic [4:0]    rf_raddr;
    logic [31:0]   dmem_raddr;
    logic [DW-1:0] rf_rdata, dmem_rdata, out_data;
    logic [8:0]    out_tag;
    logic [2:0]    dbg_state;

    logic          halt_req0, out_valid0, busy0, done0;
    logic [4:0]    rf_raddr0;
    logic [31:0]   dmem_raddr0;
    logic [DW-1:0] rf_rdata0, dmem_rdata0, out_data0;
    logic [8:0]    out_tag0;
    logic [2:0]    dbg_state0;

    logic [DW-1:0] regs [NREG];
    logic [DW-1:0] mem  [16];

    logic [40:0] exp_q[$];
    logic [40:0] exp0_q[$];
    logic [40:0] log_q[$];

    int n_checks  = 0;
    int n_fail    = 0;
    int done_cnt  = 0;
    int done0_cnt = 0;

    debug_state_dumper #(.DATA_WIDTH(DW), .NUM_REGS(NREG), .MEM_WORDS(NMEM)) dut (
        .clock(clock), .reset(reset), .start(start), .halt_req(halt_req),
        .pipe_empty(pipe_empty), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .dmem_raddr(dmem_raddr), .dmem_rdata(dmem_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    debug_state_dumper #(.DATA_WIDTH(DW), .NUM_REGS(NREG), .MEM_WORDS(0)) dut0 (
        .clock(clock), .reset(reset), .start(start0), .halt_req(halt_req0),
        .pipe_empty(pipe_empty), .rf_raddr(rf_raddr0), .rf_rdata(rf_rdata0),
        .dmem_raddr(dmem_raddr0), .dmem_rdata(dmem_rdata0), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(out_data0), .out_tag(out_tag0),
        .busy(busy0), .done(done0), .dbg_state(dbg_state0)
    );

    // Clock and combinational register-file / data-memory models.
    always #5 clock = ~clock;

    assign rf_rdata    = regs[rf_raddr];
    assign rf_rdata0   = regs[rf_raddr0];
    assign dmem_rdata  = (dmem_raddr < 32'd40) ? mem[dmem_raddr[5:2]] : 32'hdeadbeef;
    assign dmem_rdata0 = mem[dmem_raddr0[5:2]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push_expected(input bit with0);
        for (int i = 0; i < NREG; i++) begin
            exp_q.push_back({1'b0, 8'(i), regs[i]});
            if (with0) exp0_q.push_back({1'b0, 8'(i), regs[i]});
        end
        for (int j = 0; j < NMEM; j++) exp_q.push_back({1'b1, 8'(j), mem[j]});
    endtask

    // Scoreboard for the full instance: pops on every accepted beat, checks stalls hold.
    logic        stalled = 1'b0;
    logic [40:0] held = '0;
    logic [40:0] e_dut = '0;
    always @(negedge clock) begin
        #2;
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_hold", 64'({out_tag, out_data}), 64'(held));
            end
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                log_q.push_back({out_tag, out_data});
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_beat: actual %0h required no beat", {out_tag, out_data});
                end else begin
                    e_dut = exp_q.pop_front();
                    check("beat", 64'({out_tag, out_data}), 64'(e_dut));
                end
            end
            stalled = out_valid && !out_ready;
            held    = {out_tag, out_data};
        end
    end

    // Scoreboard for the MEM_WORDS=0 instance.
    logic        stalled0 = 1'b0;
    logic [40:0] held0 = '0;
    logic [40:0] e_dut0 = '0;
    always @(negedge clock) begin
        #2;
        if (reset) begin
            stalled0 = 1'b0;
        end else begin
            check("dmem0_addr", 64'(dmem_raddr0), 64'd0);
            if (stalled0) begin
                check("stall0_valid", 64'(out_valid0), 64'd1);
                check("stall0_hold", 64'({out_tag0, out_data0}), 64'(held0));
            end
            if (done0) done0_cnt++;
            if (out_valid0 && out_ready) begin
                if (exp0_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_beat0: actual %0h required no beat", {out_tag0, out_data0});
                end else begin
                    e_dut0 = exp0_q.pop_front();
                    check("beat0", 64'({out_tag0, out_data0}), 64'(e_dut0));
                end
            end
            stalled0 = out_valid0 && !out_ready;
            held0    = {out_tag0, out_data0};
        end
    end

    // One complete dump on both instances; cyc counts negedges after the edge that samples start.
    task automatic run_dump(input vec_t v, input bit hold);
        int cyc;
        int dcyc;
        int dcyc0;
        int dc;
        int dc0;
        push_expected(1'b1);
        log_q.delete();
        dc    = done_cnt;
        dc0   = done0_cnt;
        dcyc  = -1;
        dcyc0 = -1;
        @(negedge clock);
        start      = 1'b1;
        start0     = 1'b1;
        pipe_empty = (v.pe_delay == 0);
        out_ready  = ($urandom_range(99) < v.ready_pct);
        @(posedge clock);
        @(negedge clock);
        cyc = 0;
        check("halt_latency", 64'(halt_req), 64'd1);
        check("busy_latency", 64'(busy), 64'd1);
        start  = hold;
        start0 = 1'b0;
        while (dcyc < 0 && cyc < 3000) begin
            if (cyc >= 1 && cyc <= v.pe_delay) begin
                check("halt_wait_req", 64'(halt_req), 64'd1);
                check("halt_wait_valid", 64'(out_valid), 64'd0);
            end
            if (cyc == v.pe_delay + 2) check("first_beat_early", 64'(out_valid), 64'd0);
            if (cyc == v.pe_delay + 3) check("first_beat", 64'(out_valid), 64'd1);
            if (done0 && dcyc0 < 0) dcyc0 = cyc;
            if (done) begin
                dcyc = cyc;
            end else begin
                if (cyc == v.pe_delay) pipe_empty = 1'b1;
                out_ready = ($urandom_range(99) < v.ready_pct);
                if (v.noise) begin
                    start  = (cyc < v.pe_delay + 10) ? 1'($urandom_range(1)) : 1'b0;
                    start0 = start;
                end
                @(negedge clock);
                cyc++;
            end
        end
        if (dcyc < 0) check("done_timeout", 64'd0, 64'd1);
        if (v.exp_cycles >= 0) begin
            check("done_cycle", 64'(dcyc), 64'(v.exp_cycles));
            check("done0_cycle", 64'(dcyc0), 64'(v.exp_cycles - NMEM));
        end
        @(negedge clock);
        #3;
        check("done_pulse", 64'(done), 64'd0);
        check("done_count", 64'(done_cnt - dc), 64'd1);
        check("done0_count", 64'(done0_cnt - dc0), 64'd1);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("queue0_empty", 64'(exp0_q.size()), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_state", 64'(dbg_state), 64'd0);
    endtask

    initial begin
        vec_t tbl[5];
        int   cyc;
        int   dcyc;
        int   k;

        tbl[0] = '{0, 100, 1'b0, 0 + 3 + NREG + NMEM};
        tbl[1] = '{5, 100, 1'b0, 5 + 3 + NREG + NMEM};
        tbl[2] = '{2, 50, 1'b1, -1};
        tbl[3] = '{1, 30, 1'b0, -1};
        tbl[4] = '{0, 75, 1'b1, -1};

        for (int i = 0; i < NREG; i++) regs[i] = $urandom;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        regs[0]  = '0;
        regs[10] = 32'd10;
        regs[11] = 32'd3;
        regs[12] = 32'd7;
        mem[0]   = 32'd10;
        mem[1]   = 32'd3;
        mem[2]   = 32'd7;

        #1 reset = 1'b1;
        #2;
        check("rst_halt", 64'(halt_req), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_tag", 64'(out_tag), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        repeat (3) @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_dump(tbl[i], 1'b0);
            if (i == 0) begin
                check("beat_count", 64'(log_q.size()), 64'(NREG + NMEM));
                if (log_q.size() == NREG + NMEM) begin
                    check("beat10", 64'(log_q[10]), {23'd0, 9'h00a, 32'd10});
                    check("beat34", 64'(log_q[34]), {23'd0, 9'h102, 32'd7});
                end
            end
        end

        // start held high: the second dump must wait for DONE and the return to IDLE.
        run_dump(tbl[0], 1'b1);
        @(negedge clock);
        check("retrigger_halt", 64'(halt_req), 64'd1);
        check("retrigger_state", 64'(dbg_state), 64'd1);
        start = 1'b0;
        push_expected(1'b0);
        out_ready = 1'b1;
        cyc  = 0;
        dcyc = -1;
        while (dcyc < 0 && cyc < 3000) begin
            if (done) begin
                dcyc = cyc;
            end else begin
                @(negedge clock);
                cyc++;
            end
        end
        check("redo_cycle", 64'(dcyc), 64'(3 + NREG + NMEM));
        @(negedge clock);
        #3;
        check("redo_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of REGS while a beat is stalled.
        push_expected(1'b1);
        @(negedge clock);
        start = 1'b1;
        start0 = 1'b1;
        pipe_empty = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        start0 = 1'b0;
        k = 0;
        while (!(out_valid && out_tag >= 9'd5) && k < 100) begin
            @(negedge clock);
            k++;
        end
        check("reset_setup", 64'(k < 100), 64'd1);
        out_ready = 1'b0;
        @(negedge clock);
        #3 reset = 1'b1;
        #1;
        check("mid_rst_halt", 64'(halt_req), 64'd0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_data", 64'(out_data), 64'd0);
        check("mid_rst_tag", 64'(out_tag), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_rfaddr", 64'(rf_raddr), 64'd0);
        check("mid_rst_dmaddr", 64'(dmem_raddr), 64'd0);
        exp_q.delete();
        exp0_q.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        #3;
        check("post_rst_state", 64'(dbg_state), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_halt", 64'(halt_req), 64'd0);

        run_dump(tbl[0], 1'b0);

        check("final_queue", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
